// File: rtl/dbus_issuer_pkg.sv
// rtl/dbus_issuer_pkg.sv - shared types and constants for the MEMORY-stage data-bus issuer
package dbus_issuer_pkg;

  // Bus transfer size encoding; every request uses a full word.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  // MIPS primary opcodes of the only instructions that reach the data bus.
  localparam logic [5:0] ICODE_LW = 6'h23;
  localparam logic [5:0] ICODE_SW = 6'h2b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  function automatic logic is_mem_op(input logic [5:0] icode);
    return (icode == ICODE_LW) || (icode == ICODE_SW);
  endfunction

endpackage

// File: rtl/dbus_issuer.sv
// rtl/dbus_issuer.sv - issues LW/SW data-bus requests and stalls the pipeline until the response
//
// Ports:
//   clk, resetn                    pipeline clock, asynchronous active-low reset
//   x_pc, x_icode, x_addr, x_wdata instruction entering MEMORY (x_pc == 0 is a bubble)
//   dreq_valid/addr/size/strobe/data  request channel, driven only from holding registers
//   dresp_addr_ok, dresp_data_ok, dresp_data  response channel
//   mem_stall                      freezes EXECUTE, the M register and everything upstream
//   m_data                         last load word returned, registered
//   addr_err                       one-cycle pulse on a misaligned LW/SW seen in IDLE
module dbus_issuer
  import dbus_issuer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       x_pc,
  input  logic [5:0]        x_icode,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              mem_stall,
  output logic [DATA_W-1:0] m_data,
  output logic              addr_err
);

  dbus_state_t       state_q, state_d;
  logic [5:0]        icode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m_data_q;

  logic x_mem_op;
  logic x_req;
  logic x_misaligned;
  logic latch_req;
  logic capture;
  logic valid_raw;
  logic stall_raw;
  logic err_raw;

  assign x_mem_op     = (x_pc != 32'd0) && is_mem_op(x_icode);
  assign x_req        = x_mem_op && (x_addr[1:0] == 2'b00);
  assign x_misaligned = x_mem_op && (x_addr[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    capture   = 1'b0;
    valid_raw = 1'b0;
    stall_raw = 1'b0;
    err_raw   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stall in the same cycle the request is seen so the M register holds it.
        if (x_req) begin
          state_d   = ADDR;
          latch_req = 1'b1;
          stall_raw = 1'b1;
        end else if (x_misaligned) begin
          err_raw = 1'b1;
        end
      end
      ADDR: begin
        valid_raw = 1'b1;
        stall_raw = 1'b1;
        // A data_ok without addr_ok here is a protocol violation and is ignored.
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            state_d = DONE;
            capture = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        stall_raw = 1'b1;
        if (dresp_data_ok) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        // The held instruction is still on x_*; never look at it here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      icode_q  <= 6'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      m_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        icode_q <= x_icode;
        addr_q  <= x_addr;
        wdata_q <= x_wdata;
      end
      if (capture && (icode_q == ICODE_LW)) begin
        m_data_q <= dresp_data;
      end
    end
  end

  // The IDLE-cycle stall and error are combinational from x_*, so they are
  // gated by resetn to stay low while reset is held.
  assign dreq_valid  = valid_raw;
  assign mem_stall   = stall_raw & resetn;
  assign addr_err    = err_raw & resetn;
  assign dreq_addr   = addr_q;
  assign dreq_data   = wdata_q;
  assign dreq_size   = MSIZE4;
  assign dreq_strobe = (icode_q == ICODE_SW) ? 4'b1111 : 4'b0000;
  assign m_data      = m_data_q;

endmodule

// File: tb/tb_dbus_issuer.sv
// tb/tb_dbus_issuer.sv - self-checking bench for dbus_issuer
module tb_dbus_issuer;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] x_pc;
  logic [5:0]  x_icode;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        mem_stall;
  logic [31:0] m_data;
  logic        addr_err;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_mdata;

  dbus_issuer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .x_pc(x_pc), .x_icode(x_icode), .x_addr(x_addr), .x_wdata(x_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mem_stall(mem_stall), .m_data(m_data), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  icode;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;
    int          dg;
    logic [31:0] rdata;
    logic        exp_issue;
    logic        exp_err;
    logic [31:0] exp_mdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction presented to MEMORY. aw = ADDR cycles before the one
  // carrying addr_ok; dg = cycles from the addr_ok cycle to data_ok (0 = same).
  task automatic run_op(input logic [31:0] pc, input logic [5:0] icode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int aw, input int dg, input logic [31:0] rdata,
                        input logic issue, input logic err);
    logic [3:0] strb;
    strb = (icode == SW) ? 4'b1111 : 4'b0000;
    x_pc = pc; x_icode = icode; x_addr = addr; x_wdata = wdata;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
    @(negedge clk);
    chk("idle_stall", 32'(mem_stall), 32'(issue));
    chk("idle_err", 32'(addr_err), 32'(err));
    chk("idle_valid", 32'(dreq_valid), 32'd0);
    chk("idle_mdata", m_data, exp_mdata);
    next_cycle();
    if (!issue) return;
    for (int k = 0; k <= aw; k++) begin
      // Scramble x_* to prove the request is driven only from the held copy.
      x_pc = $urandom | 32'h4; x_icode = 6'($urandom); x_addr = $urandom; x_wdata = $urandom;
      dresp_addr_ok = (k == aw);
      dresp_data_ok = (k == aw) ? (dg == 0) : 1'($urandom);
      dresp_data    = (k == aw && dg == 0) ? rdata : $urandom;
      @(negedge clk);
      chk("addr_valid", 32'(dreq_valid), 32'd1);
      chk("addr_addr", dreq_addr, addr);
      chk("addr_size", 32'(dreq_size), 32'd2);
      chk("addr_strobe", 32'(dreq_strobe), 32'(strb));
      chk("addr_data", dreq_data, wdata);
      chk("addr_stall", 32'(mem_stall), 32'd1);
      next_cycle();
    end
    for (int j = 1; j <= dg; j++) begin
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (j == dg);
      dresp_data    = (j == dg) ? rdata : $urandom;
      @(negedge clk);
      chk("data_valid", 32'(dreq_valid), 32'd0);
      chk("data_stall", 32'(mem_stall), 32'd1);
      next_cycle();
    end
    if (icode == LW) exp_mdata = rdata;
    // DONE: pipeline still presents the same instruction; it must not re-issue.
    x_pc = pc; x_icode = icode; x_addr = addr; x_wdata = wdata;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
    @(negedge clk);
    chk("done_stall", 32'(mem_stall), 32'd0);
    chk("done_valid", 32'(dreq_valid), 32'd0);
    chk("done_mdata", m_data, exp_mdata);
    next_cycle();
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] pc, addr;
    logic [5:0]  icode;
    logic        mem;

    vecs[0] = '{32'hBFC0_0000, LW, 32'h8000_0010, 32'h0,         0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'hBFC0_0004, SW, 32'h8000_0020, 32'h1234_5678, 2, 2, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{32'hBFC0_0008, LW, 32'h8000_0002, 32'h0,         0, 0, 32'h1111_1111, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0000, LW, 32'h8000_0030, 32'h0,         0, 0, 32'h2222_2222, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{32'hBFC0_000C, 6'h00, 32'h8000_0040, 32'h0,      0, 0, 32'h3333_3333, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{32'hBFC0_0010, SW, 32'h8000_0041, 32'h5555_5555, 0, 0, 32'h4444_4444, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{32'hBFC0_0014, LW, 32'h8000_0050, 32'h0,         1, 0, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D};
    vecs[7] = '{32'hBFC0_0018, SW, 32'h8000_0054, 32'h7777_8888, 0, 3, 32'h9999_9999, 1'b1, 1'b0, 32'h0BAD_F00D};
    vecs[8] = '{32'hBFC0_001C, LW, 32'h8000_0058, 32'h0,         3, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D};

    // Reset with a request and then a misaligned op on x_*: outputs stay quiet.
    resetn = 1'b0; exp_mdata = 32'h0;
    x_pc = 32'hBFC0_0000; x_icode = LW; x_addr = 32'h8000_0010; x_wdata = 32'h0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
    @(negedge clk);
    chk("rst_valid", 32'(dreq_valid), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_strobe", 32'(dreq_strobe), 32'd0);
    chk("rst_mdata", m_data, 32'd0);
    x_addr = 32'h8000_0003;
    #1 chk("rst_err", 32'(addr_err), 32'd0);
    x_pc = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    next_cycle();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].pc, vecs[i].icode, vecs[i].addr, vecs[i].wdata, vecs[i].aw,
             vecs[i].dg, vecs[i].rdata, vecs[i].exp_issue, vecs[i].exp_err);
      chk("vec_mdata", m_data, vecs[i].exp_mdata);
    end

    // Reset during ADDR: dreq_valid drops without waiting for a clock edge.
    x_pc = 32'hBFC0_0100; x_icode = SW; x_addr = 32'h8000_0100; x_wdata = 32'hABCD_0123;
    next_cycle();
    @(negedge clk);
    chk("rstA_valid_before", 32'(dreq_valid), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstA_valid", 32'(dreq_valid), 32'd0);
    chk("rstA_stall", 32'(mem_stall), 32'd0);
    chk("rstA_strobe", 32'(dreq_strobe), 32'd0);
    chk("rstA_mdata", m_data, 32'd0);
    exp_mdata = 32'h0;
    x_pc = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    next_cycle();

    // Reset during DATA: stall drops at once; late data_ok is abandoned.
    x_pc = 32'hBFC0_0200; x_icode = LW; x_addr = 32'h8000_0200; x_wdata = 32'h0;
    next_cycle();
    dresp_addr_ok = 1'b1;
    next_cycle();
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("rstD_stall_before", 32'(mem_stall), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstD_stall", 32'(mem_stall), 32'd0);
    chk("rstD_valid", 32'(dreq_valid), 32'd0);
    x_pc = 32'h0;
    dresp_data_ok = 1'b1; dresp_data = 32'hFFFF_0000;
    @(negedge clk);
    resetn = 1'b1;
    next_cycle();
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("rstD_idle_stall", 32'(mem_stall), 32'd0);
    chk("rstD_mdata", m_data, 32'd0);
    next_cycle();
    run_op(32'hBFC0_0300, LW, 32'h8000_0300, 32'h0, 0, 1, 32'h600D_D474, 1'b1, 1'b0);
    chk("post_rst_mdata", m_data, 32'h600D_D474);

    // Randomized instruction stream against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int sel;
      pc  = ($urandom % 5 == 0) ? 32'h0 : ($urandom | 32'h4);
      sel = $urandom % 4;
      icode = (sel < 2) ? LW : (sel == 2) ? SW : 6'($urandom);
      addr = $urandom;
      if ($urandom % 4 != 0) addr[1:0] = 2'b00;
      mem = (pc != 32'h0) && (icode == LW || icode == SW);
      run_op(pc, icode, addr, $urandom, $urandom % 4, $urandom % 4, $urandom,
             mem && (addr[1:0] == 2'b00), mem && (addr[1:0] != 2'b00));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
